// File: rtl/slice_dispatch_if.sv
// Bundles the upstream token-queue head and the downstream slice stream of
// slice_dispatch. The dispatcher takes the master view (it pops the queue and
// presents slices); the surrounding logic (queue + parser) takes the slave view.
interface slice_dispatch_if;
  // Upstream queue head, show-ahead
  logic [143:0] q_data_in;
  logic [15:0]  q_position_in;
  logic [16:0]  q_address_in;
  logic [2:0]   q_garbage_in;
  logic         q_lit_flag_in;
  logic         q_valid_in;
  logic         q_rdreq;

  // Slice presented to the parser, valid/ready handshake
  logic [143:0] s_data;
  logic [15:0]  s_position;
  logic [16:0]  s_address;
  logic         s_lit_flag;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;

  modport master (
    input  q_data_in, q_position_in, q_address_in, q_garbage_in, q_lit_flag_in,
    input  q_valid_in, s_ready,
    output q_rdreq,
    output s_data, s_position, s_address, s_lit_flag, s_last, s_valid
  );

  modport slave (
    output q_data_in, q_position_in, q_address_in, q_garbage_in, q_lit_flag_in,
    output q_valid_in, s_ready,
    input  q_rdreq,
    input  s_data, s_position, s_address, s_lit_flag, s_last, s_valid
  );
endinterface

// File: rtl/slice_dispatch.sv
// Slice dispatcher: pops token slices from a show-ahead queue once a file is
// armed by start, buffers them in a 2-entry FIFO, masks garbage position bits,
// flags the final slice, and checks that slice addresses advance by ADDR_STEP.
module slice_dispatch #(
  parameter int unsigned ADDR_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  slice_dispatch_if.master  bus,
  output logic              done,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [143:0] data;
    logic [15:0]  position;
    logic [16:0]  address;
    logic         lit_flag;
    logic         last;
  } entry_t;

  localparam logic [16:0] STEP = 17'(ADDR_STEP);

  state_t      state;
  entry_t      mem [2];
  entry_t      head;
  entry_t      new_entry;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [16:0] exp_addr;
  logic        first_pop;
  logic        push;
  logic        pop;

  // A slice leaves the FIFO whenever the head is valid and the parser accepts it.
  assign pop  = (count != 2'd0) & bus.s_ready;
  // Pop the queue only while running; a full FIFO may accept only when it drains this cycle.
  assign push = (state == RUN) & bus.q_valid_in &
                ((count < 2'd2) | ((count == 2'd2) & pop));

  assign bus.q_rdreq = push;

  // Outputs come straight from the FIFO head register.
  assign head           = mem[rd_ptr];
  assign bus.s_valid    = (count != 2'd0);
  assign bus.s_data     = head.data;
  assign bus.s_position = head.position;
  assign bus.s_address  = head.address;
  assign bus.s_lit_flag = head.lit_flag;
  assign bus.s_last     = head.last;

  // Build the entry to store: clear the top g position bits, mark the final slice.
  // NOTE: every field is assigned on every pass, so no latch can be inferred.
  always_comb begin
    new_entry.data     = bus.q_data_in;
    new_entry.position = bus.q_position_in & (16'hFFFF >> bus.q_garbage_in);
    new_entry.address  = bus.q_address_in;
    new_entry.lit_flag = bus.q_lit_flag_in;
    new_entry.last     = (bus.q_garbage_in != 3'd0);
  end

  // Two-entry FIFO storage, pointers and occupancy.
  // NOTE: the storage is reset too, so the s_* outputs read 0 while rst is held;
  // with only two entries that costs little and keeps the outputs defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Control FSM: arm on start, stop popping after the final slice, pulse done when it leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (push && new_entry.last) state <= DRAIN;
        DRAIN: begin
          if (pop && head.last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address sequence checker: the first pop seeds the expectation, later pops compare and advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr  <= 17'd0;
      first_pop <= 1'b0;
      addr_err  <= 1'b0;
    end else if ((state == IDLE) && start) begin
      first_pop <= 1'b1;
      addr_err  <= 1'b0;
    end else if (push) begin
      if (first_pop) begin
        exp_addr  <= bus.q_address_in + STEP;
        first_pop <= 1'b0;
      end else begin
        if (bus.q_address_in != exp_addr) begin
          addr_err <= 1'b1;
        end
        exp_addr <= exp_addr + STEP;
      end
    end
  end

endmodule

// File: tb/tb_slice_dispatch.sv
// Directed testbench for slice_dispatch: a show-ahead queue model feeds the
// dispatcher, and every transferred slice is compared with hand-computed values.
module tb_slice_dispatch;

  localparam int unsigned ADDR_STEP = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic done;
  logic addr_err;

  slice_dispatch_if bus ();

  slice_dispatch #(.ADDR_STEP(ADDR_STEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .done     (done),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [143:0] data;
    logic [15:0]  pos;
    logic [16:0]  addr;
    logic [2:0]   g;
    logic         lit;
    logic [15:0]  exp_pos;
    logic         exp_last;
  } slice_t;

  slice_t src_q [$];
  slice_t exp_q [$];

  int   errors = 0;
  int   checks = 0;
  int   pop_cnt;
  int   xfer_cnt;
  int   done_cnt;
  logic smp_rd;
  logic smp_valid;
  logic smp_err;
  logic smp_done;
  logic prev_hold;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present the queue head (show-ahead) on the upstream inputs.
  task automatic drive_head();
    if (src_q.size() != 0) begin
      bus.q_valid_in    = 1'b1;
      bus.q_data_in     = src_q[0].data;
      bus.q_position_in = src_q[0].pos;
      bus.q_address_in  = src_q[0].addr;
      bus.q_garbage_in  = src_q[0].g;
      bus.q_lit_flag_in = src_q[0].lit;
    end else begin
      bus.q_valid_in    = 1'b0;
      bus.q_data_in     = '0;
      bus.q_position_in = '0;
      bus.q_address_in  = '0;
      bus.q_garbage_in  = '0;
      bus.q_lit_flag_in = 1'b0;
    end
  endtask

  task automatic push_slice(input logic [143:0] data, input logic [15:0] pos,
                            input logic [16:0] addr, input logic [2:0] g, input logic lit,
                            input logic [15:0] exp_pos, input logic exp_last);
    slice_t s;
    s.data = data; s.pos = pos; s.addr = addr; s.g = g; s.lit = lit;
    s.exp_pos = exp_pos; s.exp_last = exp_last;
    src_q.push_back(s);
    exp_q.push_back(s);
    drive_head();
  endtask

  task automatic reset_counts();
    pop_cnt  = 0;
    xfer_cnt = 0;
    done_cnt = 0;
    smp_done = 1'b0;
  endtask

  // One clock cycle: called at a falling edge, samples 1 time unit before the
  // rising edge, then returns at the next falling edge with the queue updated.
  task automatic cycle();
    logic xfer;
    #4;
    smp_rd    = bus.q_rdreq;
    smp_valid = bus.s_valid;
    smp_err   = addr_err;
    smp_done  = done;
    xfer      = bus.s_valid && bus.s_ready;
    if (prev_hold) check("valid_hold", bus.s_valid, 1'b1);
    prev_hold = bus.s_valid && !bus.s_ready;
    if (smp_done) done_cnt++;
    if (smp_rd) pop_cnt++;
    if (xfer) begin
      xfer_cnt++;
      if (exp_q.size() != 0) begin
        check("s_data",     bus.s_data,     exp_q[0].data);
        check("s_position", bus.s_position, exp_q[0].exp_pos);
        check("s_address",  bus.s_address,  exp_q[0].addr);
        check("s_lit_flag", bus.s_lit_flag, exp_q[0].lit);
        check("s_last",     bus.s_last,     exp_q[0].exp_last);
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    if (smp_rd && src_q.size() != 0) void'(src_q.pop_front());
    drive_head();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!smp_done && n < budget) begin
      cycle();
      n++;
    end
    check(tag, smp_done, 1'b1);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bus.s_ready = 1'b0;
    prev_hold   = 1'b0;
    reset_counts();
    drive_head();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_s_valid",    bus.s_valid,    1'b0);
    check("rst_q_rdreq",    bus.q_rdreq,    1'b0);
    check("rst_done",       done,           1'b0);
    check("rst_addr_err",   addr_err,       1'b0);
    check("rst_s_data",     bus.s_data,     144'h0);
    check("rst_s_position", bus.s_position, 16'h0);
    check("rst_s_address",  bus.s_address,  17'h0);
    rst = 1'b0;

    // Basic stream of three slices, last with garbage 3
    bus.s_ready = 1'b1;
    reset_counts();
    push_slice(144'hA1, 16'hFFFF, 17'h00000, 3'd0, 1'b0, 16'hFFFF, 1'b0);
    push_slice(144'hB2, 16'h1234, 17'h00010, 3'd0, 1'b1, 16'h1234, 1'b0);
    push_slice(144'hC3, 16'hFFFF, 17'h00020, 3'd3, 1'b0, 16'h1FFF, 1'b1);
    pulse_start();
    run_until_done("t1_done_seen", 30);
    repeat (3) cycle();
    check("t1_xfers",    xfer_cnt, 3);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_addr_err", addr_err, 1'b0);

    // Backpressure: four slices, parser stalled
    bus.s_ready = 1'b0;
    reset_counts();
    push_slice(144'hD4, 16'hAAAA, 17'h00100, 3'd0, 1'b0, 16'hAAAA, 1'b0);
    push_slice(144'hE5, 16'h5555, 17'h00110, 3'd0, 1'b1, 16'h5555, 1'b0);
    push_slice(144'hF6, 16'hFFFF, 17'h00120, 3'd0, 1'b0, 16'hFFFF, 1'b0);
    push_slice(144'h07, 16'h8001, 17'h00130, 3'd1, 1'b0, 16'h0001, 1'b1);
    pulse_start();
    repeat (8) cycle();
    check("t2_pops_stalled",  pop_cnt,   2);
    check("t2_rdreq_stalled", smp_rd,    1'b0);
    check("t2_valid_stalled", smp_valid, 1'b1);
    check("t2_xfers_stalled", xfer_cnt,  0);
    bus.s_ready = 1'b1;
    run_until_done("t2_done_seen", 30);
    check("t2_pops",     pop_cnt,  4);
    check("t2_xfers",    xfer_cnt, 4);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_addr_err", addr_err, 1'b0);

    // Address gap 0x00000 -> 0x00030
    reset_counts();
    push_slice(144'h11, 16'h0F0F, 17'h00000, 3'd0, 1'b0, 16'h0F0F, 1'b0);
    push_slice(144'h22, 16'hFFFF, 17'h00030, 3'd2, 1'b0, 16'h3FFF, 1'b1);
    pulse_start();
    cycle();
    check("t3_pop1",       smp_rd,  1'b1);
    cycle();
    check("t3_pop2",       smp_rd,  1'b1);
    check("t3_err_before", smp_err, 1'b0);
    cycle();
    check("t3_err_after",  smp_err, 1'b1);
    run_until_done("t3_done_seen", 20);
    repeat (3) cycle();
    check("t3_err_sticky", addr_err, 1'b1);
    check("t3_xfers",      xfer_cnt, 2);

    // Address wrap 0x1FFF0 -> 0x00000; the start also clears the previous error
    reset_counts();
    push_slice(144'h33, 16'hFFFF, 17'h1FFF0, 3'd0, 1'b0, 16'hFFFF, 1'b0);
    push_slice(144'h44, 16'hFFFF, 17'h00000, 3'd4, 1'b1, 16'h0FFF, 1'b1);
    pulse_start();
    cycle();
    check("t4_err_cleared", smp_err, 1'b0);
    run_until_done("t4_done_seen", 20);
    check("t4_addr_err", addr_err, 1'b0);
    check("t4_xfers",    xfer_cnt, 2);

    // Reset with the FIFO full, then idle guard until the next start
    bus.s_ready = 1'b0;
    reset_counts();
    push_slice(144'h55, 16'h1111, 17'h00200, 3'd0, 1'b0, 16'h1111, 1'b0);
    push_slice(144'h66, 16'h2222, 17'h00210, 3'd0, 1'b0, 16'h2222, 1'b0);
    push_slice(144'h77, 16'h3333, 17'h00220, 3'd0, 1'b0, 16'h3333, 1'b0);
    pulse_start();
    repeat (4) cycle();
    check("t5_pops_before_rst",  pop_cnt,   2);
    check("t5_valid_before_rst", smp_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid",  bus.s_valid, 1'b0);
    check("t5_rst_rdreq",  bus.q_rdreq, 1'b0);
    check("t5_rst_data",   bus.s_data,  144'h0);
    @(negedge clk);
    rst         = 1'b0;
    bus.s_ready = 1'b1;
    prev_hold   = 1'b0;
    exp_q       = src_q;
    reset_counts();
    repeat (10) cycle();
    check("t5_idle_pops",  pop_cnt,   0);
    check("t5_idle_xfers", xfer_cnt,  0);
    check("t5_idle_valid", smp_valid, 1'b0);
    push_slice(144'h88, 16'hFFFF, 17'h00230, 3'd5, 1'b0, 16'h07FF, 1'b1);
    pulse_start();
    run_until_done("t5_done_seen", 20);
    check("t5_xfers",    xfer_cnt, 2);
    check("t5_addr_err", addr_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slice_dispatch.md
SLICE_DISPATCH -- requirements
Module: slice_dispatch

Interface
REQ-001 The block SHALL have parameter ADDR_STEP, default 16, meaning expected address increment between consecutive slices.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, meaning a one-cycle pulse that arms a new file.
REQ-005 The block SHALL have ports q_data_in (144), q_position_in (16), q_address_in (17), q_garbage_in (3), q_lit_flag_in (1), all inputs, meaning the head fields of the upstream token queue.
REQ-006 The block SHALL have port q_valid_in, input, 1, meaning the queue head is valid; head fields are show-ahead.
REQ-007 The block SHALL have port q_rdreq, output, 1, meaning pop the queue head this cycle.
REQ-008 The block SHALL have ports s_data (144), s_position (16), s_address (17), s_lit_flag (1), all outputs, meaning the slice presented to the parser.
REQ-009 The block SHALL have port s_last, output, 1, meaning the presented slice is the final slice of the file.
REQ-010 The block SHALL have ports s_valid (output, 1) and s_ready (input, 1), meaning a valid/ready handshake; transfer occurs when both are high.
REQ-011 The block SHALL have ports done (output, 1), meaning one-cycle pulse after the last slice transfers, and addr_err (output, 1), meaning sticky address-sequence error.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DRAIN; reset state SHALL be IDLE.
- IDLE->RUN on start.
- RUN->DRAIN when a slice with q_garbage_in!=0 is popped.
- DRAIN->IDLE when the buffered last slice transfers; done SHALL pulse in that same cycle.
REQ-013 A 2-entry FIFO buffer SHALL sit between the queue and the output; its occupancy counter SHALL be 2 bits (values 0..2).
REQ-014 q_rdreq SHALL be the combinational value (state==RUN) & q_valid_in & (occupancy<2 | (occupancy==2 & s_valid & s_ready)).
REQ-015 A popped entry SHALL be written on the same edge; it SHALL appear on the outputs no earlier than the following cycle; minimum latency from q_rdreq to s_valid SHALL be 1 cycle.
REQ-016 s_valid SHALL equal (occupancy!=0); the s_* outputs SHALL come from the FIFO head only.
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; push into full occupancy without a pop SHALL never occur.
REQ-018 On push, position SHALL be masked: bits [15:16-g] cleared where g=q_garbage_in; g=0 SHALL mean no masking; data and lit_flag SHALL pass unmodified.
REQ-019 s_last SHALL be 1 for an entry whose garbage was nonzero.
REQ-020 The first popped slice after start SHALL load the expected address with q_address_in + ADDR_STEP (17-bit, wrap modulo 2^17).
- Each later pop SHALL compare q_address_in to the expected address, then advance the expected address by ADDR_STEP.
REQ-021 On a mismatch, addr_err SHALL set the next cycle and stay set until rst or start.
REQ-022 start in RUN or DRAIN SHALL be ignored.
REQ-023 In IDLE and DRAIN, q_rdreq SHALL be 0 regardless of q_valid_in.
REQ-024 s_valid SHALL never deassert without a transfer once asserted.

Reset
REQ-025 Asynchronous rst assertion SHALL immediately force:
- state IDLE, occupancy 0, s_valid 0, q_rdreq 0, done 0, addr_err 0, expected address 0;
- s_* data outputs 0.
REQ-026 Reset mid-operation SHALL discard buffered entries; no partial transfer SHALL complete after rst.
REQ-027 After rst deasserts, the block SHALL require a start pulse before popping.

Verification
REQ-028 Stream: start; queue holds 3 slices at addresses 0x00000, 0x00010, 0x00020, the last with garbage=3; s_ready=1 -> three transfers in order; last has s_last=1 and position[15:13]=0; done pulses once; addr_err=0.
REQ-029 Backpressure: s_ready=0 with 4 queued slices -> exactly 2 pops, then q_rdreq=0; set s_ready=1 -> remaining slices pop; all 4 transfer in order with no duplication.
REQ-030 Address gap: slices at 0x00000 then 0x00030 -> addr_err=1 the cycle after the second pop and stays 1; a following start clears it.
REQ-031 Wrap: first slice address 0x1FFF0, second 0x00000 -> addr_err remains 0.
REQ-032 Reset mid-stream: rst asserted with occupancy 2 -> s_valid=0 and occupancy 0 immediately; slices queued after reset are not popped until start.
REQ-033 Idle guard: q_valid_in=1 with no start -> q_rdreq stays 0 for 10 cycles.
